// File: rtl/lc_transition_requester.sv
// Host-facing requester that forwards one lifecycle transition at a time to the protector.
// Optional request timeout is enabled with `define LC_REQ_TIMEOUT_EN.
module lc_transition_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [511:0] cmd_identifier,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [1:0]   resp_status,
    output logic [2:0]   resp_state,
    output logic         lc_transition_request,
    output logic [511:0] lc_identifier,
    input  logic         lc_done,
    input  logic         lc_success,
    input  logic [2:0]   lc_state
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RELEASE,
        ST_RESP
    } state_e;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_REJECT  = 2'b01;
    localparam logic [1:0] STATUS_EOL     = 2'b10;
    localparam logic [2:0] LC_EOL_MIN     = 3'b101;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

    state_e       state_q, state_d;
    logic [511:0] id_q, id_d;
    logic [1:0]   status_q, status_d;
    logic [2:0]   rstate_q, rstate_d;

`ifdef LC_REQ_TIMEOUT_EN
    localparam logic [1:0]  STATUS_TIMEOUT = 2'b11;
    localparam logic [15:0] TIMEOUT_LAST   = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        status_d = status_q;
        rstate_d = rstate_q;
`ifdef LC_REQ_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (lc_state < LC_EOL_MIN) begin
                        id_d    = cmd_identifier;
                        state_d = ST_REQ;
`ifdef LC_REQ_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        status_d = STATUS_EOL;
                        rstate_d = lc_state;
                        id_d     = '0;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                // lc_done wins over a coincident terminal count
                if (lc_done) begin
                    status_d = lc_success ? STATUS_OK : STATUS_REJECT;
                    rstate_d = lc_state;
                    state_d  = ST_RELEASE;
                end
`ifdef LC_REQ_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    status_d = STATUS_TIMEOUT;
                    rstate_d = lc_state;
                    state_d  = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ST_RELEASE: begin
                if (!lc_done) begin
                    id_d    = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the wide identifier register is reset because a mid-transaction reset must scrub the signature.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            status_q <= '0;
            rstate_q <= '0;
`ifdef LC_REQ_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            status_q <= status_d;
            rstate_q <= rstate_d;
`ifdef LC_REQ_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign cmd_ready             = (state_q == ST_IDLE) && !rst;
    assign lc_transition_request = (state_q == ST_REQ);
    assign lc_identifier         = lc_transition_request ? id_q : '0;
    assign resp_valid            = (state_q == ST_RESP);
    assign resp_status           = status_q;
    assign resp_state            = rstate_q;

endmodule

// File: tb/tb_lc_transition_requester.sv
// Directed bench for lc_transition_requester: vector table plus reset, backpressure and timeout sequences.
module tb_lc_transition_requester;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [511:0] cmd_identifier;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_status;
    logic [2:0]   resp_state;
    logic         lc_transition_request;
    logic [511:0] lc_identifier;
    logic         lc_done;
    logic         lc_success;
    logic [2:0]   lc_state;

    int n_tests = 0;
    int n_fail  = 0;

    lc_transition_requester #(.TIMEOUT_CYCLES(8)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_identifier        (cmd_identifier),
        .resp_valid            (resp_valid),
        .resp_ready            (resp_ready),
        .resp_status           (resp_status),
        .resp_state            (resp_state),
        .lc_transition_request (lc_transition_request),
        .lc_identifier         (lc_identifier),
        .lc_done               (lc_done),
        .lc_success            (lc_success),
        .lc_state              (lc_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [2:0]   start_state;
        logic [511:0] id;
        logic         exp_req;
        logic         success;
        logic [2:0]   done_state;
        int           wait_cycles;
        int           done_len;
        logic [1:0]   exp_status;
        logic [2:0]   exp_state;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input string name);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({name, ".resp_valid_after_hs"}, 512'(resp_valid), 512'(1'b0));
        check({name, ".cmd_ready_after_hs"}, 512'(cmd_ready), 512'(1'b1));
    endtask

    task automatic run_vec(input vec_t v);
        lc_state       = v.start_state;
        cmd_identifier = v.id;
        cmd_valid      = 1'b1;
        #1;
        check({v.name, ".cmd_ready"}, 512'(cmd_ready), 512'(1'b1));
        tick();
        cmd_valid = 1'b0;
        if (v.exp_req) begin
            check({v.name, ".req_rise"}, 512'(lc_transition_request), 512'(1'b1));
            check({v.name, ".id_out"}, lc_identifier, v.id);
            cmd_valid      = 1'b1;
            cmd_identifier = ~v.id;
            for (int i = 0; i < v.wait_cycles; i++) begin
                tick();
                check({v.name, ".req_hold"}, 512'(lc_transition_request), 512'(1'b1));
                check({v.name, ".id_hold"}, lc_identifier, v.id);
                check({v.name, ".cmd_ready_busy"}, 512'(cmd_ready), 512'(1'b0));
            end
            cmd_valid  = 1'b0;
            lc_done    = 1'b1;
            lc_success = v.success;
            lc_state   = v.done_state;
            tick();
            check({v.name, ".req_fall"}, 512'(lc_transition_request), 512'(1'b0));
            check({v.name, ".id_zero"}, lc_identifier, 512'(0));
            check({v.name, ".resp_early"}, 512'(resp_valid), 512'(1'b0));
            lc_state = v.start_state;
            for (int i = 1; i < v.done_len; i++) begin
                tick();
                check({v.name, ".release_wait"}, 512'(resp_valid), 512'(1'b0));
                check({v.name, ".release_req"}, 512'(lc_transition_request), 512'(1'b0));
            end
            lc_done    = 1'b0;
            lc_success = 1'b0;
            tick();
        end else begin
            check({v.name, ".no_req"}, 512'(lc_transition_request), 512'(1'b0));
        end
        check({v.name, ".resp_valid"}, 512'(resp_valid), 512'(1'b1));
        check({v.name, ".resp_status"}, 512'(resp_status), 512'(v.exp_status));
        check({v.name, ".resp_state"}, 512'(resp_state), 512'(v.exp_state));
        check({v.name, ".cmd_ready_resp"}, 512'(cmd_ready), 512'(1'b0));
        check({v.name, ".id_resp"}, lc_identifier, 512'(0));
        handshake(v.name);
    endtask

    initial begin
        vecs[0] = '{"success",  3'b001, {16{32'hA5A5_0001}}, 1'b1, 1'b1, 3'b010, 3, 1, 2'b00, 3'b010};
        vecs[1] = '{"reject",   3'b010, {16{32'h0BAD_0BAD}}, 1'b1, 1'b0, 3'b010, 1, 3, 2'b01, 3'b010};
        vecs[2] = '{"eol101",   3'b101, {16{32'h1234_5678}}, 1'b0, 1'b0, 3'b000, 0, 0, 2'b10, 3'b101};
        vecs[3] = '{"eol110",   3'b110, {16{32'h8765_4321}}, 1'b0, 1'b0, 3'b000, 0, 0, 2'b10, 3'b110};
        vecs[4] = '{"edge100",  3'b100, {16{32'hFFFF_0000}}, 1'b1, 1'b1, 3'b101, 0, 2, 2'b00, 3'b101};

        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_identifier = '0;
        resp_ready     = 1'b0;
        lc_done        = 1'b0;
        lc_success     = 1'b0;
        lc_state       = 3'b001;
        repeat (2) tick();
        check("rst.cmd_ready", 512'(cmd_ready), 512'(1'b0));
        check("rst.resp_valid", 512'(resp_valid), 512'(1'b0));
        check("rst.req", 512'(lc_transition_request), 512'(1'b0));
        check("rst.status", 512'(resp_status), 512'(2'b00));
        check("rst.state", 512'(resp_state), 512'(3'b000));
        check("rst.id", lc_identifier, 512'(0));
        rst = 1'b0;
        #1;
        check("rst.cmd_ready_release", 512'(cmd_ready), 512'(1'b1));

        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k]);
        end

        // lc_done while idle must not start anything
        lc_done    = 1'b1;
        lc_success = 1'b1;
        repeat (2) tick();
        check("idle_done.resp_valid", 512'(resp_valid), 512'(1'b0));
        check("idle_done.cmd_ready", 512'(cmd_ready), 512'(1'b1));
        lc_done    = 1'b0;
        lc_success = 1'b0;

        // backpressure: response held stable with resp_ready low
        lc_state  = 3'b110;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        lc_state  = 3'b001;
        lc_done   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp.resp_valid", 512'(resp_valid), 512'(1'b1));
            check("bp.status", 512'(resp_status), 512'(2'b10));
            check("bp.state", 512'(resp_state), 512'(3'b110));
            check("bp.cmd_ready", 512'(cmd_ready), 512'(1'b0));
            tick();
        end
        lc_done = 1'b0;
        // reset while a response is pending
        #2;
        rst = 1'b1;
        #1;
        check("rst_resp.resp_valid", 512'(resp_valid), 512'(1'b0));
        check("rst_resp.status", 512'(resp_status), 512'(2'b00));
        check("rst_resp.state", 512'(resp_state), 512'(3'b000));
        tick();
        rst = 1'b0;
        #1;
        check("rst_resp.cmd_ready", 512'(cmd_ready), 512'(1'b1));

        // reset while requesting
        lc_state       = 3'b001;
        cmd_identifier = {16{32'hDEAD_BEEF}};
        cmd_valid      = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("rst_req.req_pre", 512'(lc_transition_request), 512'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        check("rst_req.req", 512'(lc_transition_request), 512'(1'b0));
        check("rst_req.id", lc_identifier, 512'(0));
        check("rst_req.cmd_ready", 512'(cmd_ready), 512'(1'b0));
        tick();
        rst = 1'b0;
        #1;
        check("rst_req.cmd_ready_release", 512'(cmd_ready), 512'(1'b1));
        run_vec(vecs[0]);

`ifdef LC_REQ_TIMEOUT_EN
        // silent responder: request lasts exactly 8 cycles, then status 11
        lc_state  = 3'b011;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        lc_state  = 3'b100;
        for (int i = 0; i < 8; i++) begin
            check("to.req_hold", 512'(lc_transition_request), 512'(1'b1));
            tick();
        end
        check("to.req_fall", 512'(lc_transition_request), 512'(1'b0));
        check("to.resp_early", 512'(resp_valid), 512'(1'b0));
        tick();
        check("to.resp_valid", 512'(resp_valid), 512'(1'b1));
        check("to.status", 512'(resp_status), 512'(2'b11));
        check("to.state", 512'(resp_state), 512'(3'b100));
        handshake("to");

        // lc_done on the terminal cycle wins
        lc_state  = 3'b001;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (7) tick();
        check("to_done.req", 512'(lc_transition_request), 512'(1'b1));
        lc_done    = 1'b1;
        lc_success = 1'b0;
        lc_state   = 3'b010;
        tick();
        check("to_done.req_fall", 512'(lc_transition_request), 512'(1'b0));
        lc_done = 1'b0;
        tick();
        check("to_done.resp_valid", 512'(resp_valid), 512'(1'b1));
        check("to_done.status", 512'(resp_status), 512'(2'b01));
        check("to_done.state", 512'(resp_state), 512'(3'b010));
        handshake("to_done");
`else
        // without the timeout the request waits indefinitely
        lc_state  = 3'b001;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("wait.req_hold", 512'(lc_transition_request), 512'(1'b1));
            tick();
        end
        check("wait.resp_valid", 512'(resp_valid), 512'(1'b0));
        lc_done    = 1'b1;
        lc_success = 1'b1;
        lc_state   = 3'b011;
        tick();
        lc_done    = 1'b0;
        lc_success = 1'b0;
        tick();
        check("wait.status", 512'(resp_status), 512'(2'b00));
        check("wait.state", 512'(resp_state), 512'(3'b011));
        handshake("wait");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
